// File: rtl/uart_echo_initiator.sv
// uart_echo_initiator: sends a SEED-based FRAME_LEN byte pattern as 8N1 and checks the echo.
// Optional RECV watchdog is compiled in when UART_INIT_TIMEOUT_EN is defined.
module uart_echo_initiator #(
   parameter int         FRAME_LEN    = 256,
   parameter int         BAUD         = 115200,
   parameter int         CLK_FREQ     = 100_000_000,
   parameter logic [7:0] SEED         = 8'h00,
   parameter int         TIMEOUT_BITS = 4096
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        sig_tx,
   input  logic        sig_rx,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count,
   output logic        timeout,
   output logic [5:0]  states_led
);
   localparam int                CPB       = CLK_FREQ / BAUD;
   localparam int                CNT_W     = (CPB > 1) ? $clog2(CPB) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CPB - 1);
   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CPB / 2 - 1);
   localparam logic [8:0]        LAST_IDX  = 9'(FRAME_LEN - 1);
   localparam logic [8:0]        FRAME_END = 9'(FRAME_LEN);

   if (CPB < 4) begin : g_bad_cpb
      $error("CLK_FREQ/BAUD must be at least 4");
   end
   if (FRAME_LEN < 1 || FRAME_LEN > 256) begin : g_bad_len
      $error("FRAME_LEN must be in 1..256");
   end
   if (TIMEOUT_BITS < 1) begin : g_bad_timeout
      $error("TIMEOUT_BITS must be at least 1");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_RECV, ST_DONE} state_e;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS} rx_state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [3:0]       tx_bit_q, tx_bit_d;
   logic [8:0]       tx_idx_q, tx_idx_d;
   logic [7:0]       tx_shift_q, tx_shift_d;
   logic             sig_tx_q, sig_tx_d;
   logic [1:0]       rx_sync_q;
   logic             rx_prev_q;
   rx_state_e        rx_state_q, rx_state_d;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [3:0]       rx_bit_q, rx_bit_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic [8:0]       rx_idx_q, rx_idx_d;
   logic [15:0]      err_q, err_d;
   logic             pass_q, pass_d;
   logic             rx_s, rx_byte_done;
   logic [7:0]       rx_expect;
   logic [1:0]       rx_inc;
   logic [16:0]      err_sum;

`ifdef UART_INIT_TIMEOUT_EN
   localparam int             WD_W    = $clog2(TIMEOUT_BITS * CPB + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_BITS * CPB - 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            timeout_q, timeout_d;
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   // sig_rx is asynchronous; the synchronizer idles high so reset never looks like a start bit.
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_sync_q <= 2'b11;
         rx_prev_q <= 1'b1;
      end else begin
         rx_sync_q <= {rx_sync_q[0], sig_rx};
         rx_prev_q <= rx_sync_q[1];
      end
   end
   assign rx_s = rx_sync_q[1];

   always_comb begin
      // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
      state_d      = state_q;
      tx_cnt_d     = tx_cnt_q;
      tx_bit_d     = tx_bit_q;
      tx_idx_d     = tx_idx_q;
      tx_shift_d   = tx_shift_q;
      sig_tx_d     = sig_tx_q;
      rx_state_d   = rx_state_q;
      rx_cnt_d     = rx_cnt_q;
      rx_bit_d     = rx_bit_q;
      rx_shift_d   = rx_shift_q;
      rx_idx_d     = rx_idx_q;
      err_d        = err_q;
      pass_d       = pass_q;
      rx_byte_done = 1'b0;
      rx_expect    = SEED + rx_idx_q[7:0];
      rx_inc       = {1'b0, (rx_shift_q != rx_expect)} + {1'b0, ~rx_s};
      err_sum      = {1'b0, err_q} + {15'd0, rx_inc};
`ifdef UART_INIT_TIMEOUT_EN
      timeout_d    = timeout_q;
      wd_d         = '0;
`endif

      if (state_q == ST_SEND || state_q == ST_RECV) begin
         case (rx_state_q)
            RX_IDLE: begin
               if (rx_prev_q && !rx_s) begin
                  rx_state_d = RX_START;
                  rx_cnt_d   = '0;
               end
            end
            RX_START: begin
               if (rx_cnt_q == HALF_LAST) begin
                  rx_cnt_d   = '0;
                  rx_bit_d   = '0;
                  rx_state_d = rx_s ? RX_IDLE : RX_BITS;
               end else begin
                  rx_cnt_d = rx_cnt_q + CNT_W'(1);
               end
            end
            RX_BITS: begin
               if (rx_cnt_q == CNT_LAST) begin
                  rx_cnt_d = '0;
                  if (rx_bit_q == 4'd8) begin
                     // Stop-bit sample: byte is counted and scored even when mis-framed.
                     rx_state_d   = RX_IDLE;
                     rx_byte_done = 1'b1;
                     rx_idx_d     = rx_idx_q + 9'd1;
                     err_d        = err_sum[16] ? 16'hFFFF : err_sum[15:0];
                  end else begin
                     rx_shift_d = {rx_s, rx_shift_q[7:1]};
                     rx_bit_d   = rx_bit_q + 4'd1;
                  end
               end else begin
                  rx_cnt_d = rx_cnt_q + CNT_W'(1);
               end
            end
            default: rx_state_d = RX_IDLE;
         endcase
      end else begin
         rx_state_d = RX_IDLE;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_SEND;
               sig_tx_d   = 1'b0;
               tx_shift_d = SEED;
               tx_bit_d   = '0;
               tx_cnt_d   = '0;
               tx_idx_d   = '0;
               rx_idx_d   = '0;
               err_d      = '0;
               pass_d     = 1'b0;
`ifdef UART_INIT_TIMEOUT_EN
               timeout_d  = 1'b0;
`endif
            end
         end
         ST_SEND: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 4'd9) begin
                  if (tx_idx_q == LAST_IDX) begin
                     state_d  = ST_RECV;
                     sig_tx_d = 1'b1;
                  end else begin
                     tx_idx_d   = tx_idx_q + 9'd1;
                     tx_bit_d   = '0;
                     sig_tx_d   = 1'b0;
                     tx_shift_d = SEED + tx_idx_q[7:0] + 8'd1;
                  end
               end else if (tx_bit_q == 4'd8) begin
                  tx_bit_d = 4'd9;
                  sig_tx_d = 1'b1;
               end else begin
                  tx_bit_d   = tx_bit_q + 4'd1;
                  sig_tx_d   = tx_shift_q[0];
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
               end
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
         end
         ST_RECV: begin
            if (rx_idx_q >= FRAME_END) state_d = ST_DONE;
`ifdef UART_INIT_TIMEOUT_EN
            else if (wd_q == WD_LAST && !rx_byte_done) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
            end
            wd_d = rx_byte_done ? '0 : wd_q + WD_W'(1);
`endif
         end
         default: begin
            pass_d  = (err_q == 16'd0) && !timeout;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q    <= ST_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_idx_q   <= '0;
         tx_shift_q <= '0;
         sig_tx_q   <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_idx_q   <= '0;
         err_q      <= '0;
         pass_q     <= 1'b0;
`ifdef UART_INIT_TIMEOUT_EN
         wd_q       <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_idx_q   <= tx_idx_d;
         tx_shift_q <= tx_shift_d;
         sig_tx_q   <= sig_tx_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_idx_q   <= rx_idx_d;
         err_q      <= err_d;
         pass_q     <= pass_d;
`ifdef UART_INIT_TIMEOUT_EN
         wd_q       <= wd_d;
         timeout_q  <= timeout_d;
`endif
      end
   end

   always_comb begin
      case (state_q)
         ST_IDLE: states_led = pass_q ? 6'b001001 : 6'b000000;
         ST_SEND: states_led = 6'b010010;
         ST_RECV: states_led = 6'b100100;
         default: states_led = 6'b000000;
      endcase
   end

   assign sig_tx    = sig_tx_q;
   assign busy      = (state_q == ST_SEND) || (state_q == ST_RECV);
   assign done      = (state_q == ST_DONE);
   assign pass      = pass_q;
   assign err_count = err_q;

endmodule

// File: tb/tb_uart_echo_initiator.sv
// Bench for uart_echo_initiator: loopback and bench-driven echoes (random corruption, framing
// errors, false starts) scored against a byte-level model; watchdog run when UART_INIT_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_uart_echo_initiator;
   localparam int         FRAME_LEN    = 4;
   localparam int         CPB          = 16;
   localparam int         TIMEOUT_BITS = 20;
   localparam logic [7:0] SEED         = 8'hA0;

   logic        clock = 1'b0;
   logic        reset, start, sig_rx, sig_tx, busy, done, pass, timeout;
   logic [15:0] err_count;
   logic [5:0]  states_led;
   logic        loop_en, drv_rx;
   int          n_vec = 0;
   int          n_bad = 0;

   logic [7:0]  echo_byte [FRAME_LEN];
   logic        echo_stop [FRAME_LEN];
   int          echo_gap  [FRAME_LEN];
   int          echo_delay, glitch_len;

   assign sig_rx = loop_en ? sig_tx : drv_rx;
   always #5 clock = ~clock;

   uart_echo_initiator #(
      .FRAME_LEN(FRAME_LEN), .BAUD(1), .CLK_FREQ(16), .SEED(SEED), .TIMEOUT_BITS(TIMEOUT_BITS)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .sig_tx(sig_tx), .sig_rx(sig_rx),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count), .timeout(timeout),
      .states_led(states_led)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Score of a run: one point per wrong byte, one per low stop bit, saturating at 16 bits.
   function automatic int model_errs();
      int e = 0;
      for (int i = 0; i < FRAME_LEN; i++) begin
         if (echo_byte[i] != 8'(SEED + i)) e++;
         if (!echo_stop[i]) e++;
      end
      return (e > 65535) ? 65535 : e;
   endfunction

   task automatic clean_echo();
      for (int i = 0; i < FRAME_LEN; i++) begin
         echo_byte[i] = 8'(SEED + i);
         echo_stop[i] = 1'b1;
         echo_gap[i]  = 0;
      end
      echo_delay = 10;
      glitch_len = 0;
   endtask

   task automatic drive_echo();
      logic [9:0] fr;
      repeat (echo_delay) tick();
      if (glitch_len > 0) begin
         drv_rx = 1'b0;
         repeat (glitch_len) tick();
         drv_rx = 1'b1;
         repeat (2 * CPB) tick();
      end
      for (int i = 0; i < FRAME_LEN; i++) begin
         fr = {echo_stop[i], echo_byte[i], 1'b0};
         for (int b = 0; b < 10; b++) begin
            drv_rx = fr[b];
            repeat (CPB) tick();
         end
         drv_rx = 1'b1;
         // A low stop bit needs an idle bit before the next start edge can be seen.
         if (i < FRAME_LEN - 1) repeat (echo_gap[i] + (echo_stop[i] ? 0 : CPB)) tick();
      end
   endtask

   task automatic watch_run(input bit exp_to, input bit restart_at_done, input int exp_err);
      logic [9:0] fr;
      int         good;
      int         waited;
      bit         exp_pass;
      exp_pass = (exp_err == 0) && !exp_to;
      for (int k = 0; k < FRAME_LEN; k++) begin
         fr = {1'b1, 8'(SEED + k), 1'b0};
         for (int b = 0; b < 10; b++) begin
            good = 0;
            for (int c = 0; c < CPB; c++) begin
               @(negedge clock);
               if (k == 0 && b == 0 && c == 0) check("busy_after_start", busy, 1);
               if (sig_tx === fr[b]) good++;
            end
            check($sformatf("tx_byte%0d_bit%0d_cycles", k, b), good, CPB);
         end
      end
      check("led_send_last", states_led, 6'b010010);
      @(negedge clock);
      check("led_recv_entry", states_led, 6'b100100);
      waited = 0;
      while (done !== 1'b1 && waited < 3000) begin
         @(negedge clock);
         waited++;
      end
      check("done_seen", done, 1);
      if (exp_to) check("watchdog_latency", waited, TIMEOUT_BITS * CPB);
      check("busy_at_done", busy, 0);
      check("err_count", err_count, exp_err);
      check("timeout_flag", timeout, exp_to);
      if (restart_at_done) start = 1'b1;
      @(negedge clock);
      check("done_one_cycle", done, 0);
      check("pass", pass, exp_pass);
      check("busy_idle", busy, 0);
      check("led_idle", states_led, exp_pass ? 6'b001001 : 6'b000000);
      if (restart_at_done) begin
         @(negedge clock);
         check("restart_busy", busy, 1);
         check("restart_start_bit", sig_tx, 0);
         start = 1'b0;
      end
   endtask

   task automatic run_case(input bit use_loop, input bit echo_on, input bit hold_start_mid,
                           input bit exp_to, input bit restart_at_done, input int exp_err);
      loop_en = use_loop;
      drv_rx  = 1'b1;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      fork
         watch_run(exp_to, restart_at_done, exp_err);
         if (echo_on) drive_echo();
         if (hold_start_mid) begin
            repeat (50) tick();
            start = 1'b1;
            repeat (200) tick();
            start = 1'b0;
         end
      join
      repeat (5) tick();
   endtask

   initial begin
      #800_000;
      $display("FAIL global_timeout: got still running, expected finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      loop_en = 1'b1;
      drv_rx  = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clock);
      check("rst_sig_tx", sig_tx, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_err", err_count, 0);
      check("rst_timeout", timeout, 0);
      check("rst_led", states_led, 0);
      tick();

      // Clean loopback.
      run_case(1, 0, 0, 0, 0, 0);

      // Third echoed byte arrives as A3 instead of A2.
      clean_echo();
      echo_byte[2] = echo_byte[2] ^ 8'h01;
      run_case(0, 1, 0, 0, 0, model_errs());

      // Stop bit of echoed byte 1 low.
      clean_echo();
      echo_stop[1] = 1'b0;
      run_case(0, 1, 0, 0, 0, model_errs());

      // 3-cycle glitch on an idle line during SEND.
      clean_echo();
      echo_delay = 20;
      glitch_len = 3;
      run_case(0, 1, 0, 0, 0, model_errs());

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < FRAME_LEN; i++) begin
            echo_byte[i] = 8'(SEED + i);
            if ($urandom_range(0, 2) == 0) echo_byte[i] = echo_byte[i] ^ 8'($urandom_range(1, 255));
            echo_stop[i] = ($urandom_range(0, 3) != 0);
            echo_gap[i]  = $urandom_range(0, 20);
         end
         echo_delay = $urandom_range(0, 200);
         glitch_len = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
         run_case(0, 1, 0, 0, 0, model_errs());
      end

`ifdef UART_INIT_TIMEOUT_EN
      // No echo at all: the watchdog ends the run.
      run_case(0, 0, 0, 1, 0, 0);
`endif

      // Reset in the middle of SEND.
      loop_en = 1'b1;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      repeat (100) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clock);
      check("midrst_sig_tx", sig_tx, 1);
      check("midrst_busy", busy, 0);
      check("midrst_led", states_led, 0);
      check("midrst_err", err_count, 0);
      tick();

      // start held high while busy must not restart the run.
      run_case(1, 0, 1, 0, 0, 0);

      // start high in the DONE cycle is taken on the following IDLE cycle.
      run_case(1, 0, 0, 0, 1, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clock);
      check("final_rst_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/uart_echo_initiator.md
# uart_echo_initiator

Host-side peer of the UART echo top level. The block streams a FRAME_LEN-byte deterministic pattern out over an 8N1 serial line, then receives the echoed bytes and compares each one against the expected pattern. It sits in the bench or companion FPGA with `sig_tx` wired to the echo unit's `sig_rx` and `sig_rx` wired to its `sig_tx`. It is self-contained: it has its own bit-level serializer and deserializer and does not use `uart_if`.

## Interface
- `FRAME_LEN`, default 256: bytes per frame, range 1..256.
- `BAUD`, default 115200: line rate.
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
  - CPB = CLK_FREQ/BAUD, truncated; must be ≥ 4.
- `SEED`, default 8'h00: first pattern byte.
- `TIMEOUT_BITS`, default 4096: echo watchdog length, in bit-times. Used only with `UART_INIT_TIMEOUT_EN`.
- `clock` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-high.
- `start` in 1: level sampled each cycle; it is honoured only in IDLE.
- `sig_tx` out 1: serial output; idles high.
- `sig_rx` in 1: serial input; asynchronous.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse at the end of a run.
- `pass` out 1: result of the last run; held until the next accepted `start`.
- `err_count` out 16: mismatches plus framing errors; saturates at 16'hFFFF.
- `timeout` out 1: watchdog fired on the last run; tied 0 without the macro.
- `states_led` out 6: state indicator.

## Operation
- Pattern: byte i = (SEED + i) mod 256, for i = 0..FRAME_LEN-1.
- Framing: 8N1, LSB first. Each frame is a start bit (0), 8 data bits, then a stop bit (1).
- FSM states: IDLE, SEND, RECV, DONE.
  - IDLE → SEND on `start`. This clears `err_count`, `pass` and `timeout`, and resets the tx and rx byte indices to 0.
  - SEND: frames are sent back-to-back, with no idle gap between one stop bit and the next start bit. After the stop bit of byte FRAME_LEN-1 completes, go to RECV.
  - RECV: wait until the rx index reaches FRAME_LEN, then go to DONE.
  - DONE: lasts one cycle. `done` = 1; `pass` = (`err_count` == 0 && !`timeout`). Then go to IDLE.
- Receiver:
  - Active in SEND and RECV; echoes may overlap transmission.
  - In IDLE and DONE, line activity is ignored.
  - Input passes through a 2-flop synchronizer, reset to 1.
  - Idle-state falling edge: wait CPB/2 cycles and re-sample the line. If it is high, treat it as a false start and return to rx-idle without counting anything.
  - Otherwise sample 8 data bits and the stop bit, each CPB cycles apart (mid-bit).
  - Each completed byte: compare it with pattern[rx index], then increment the rx index. A mismatch adds 1 to `err_count`.
  - Stop bit = 0 is a framing error: add 1 to `err_count`, but the byte is still counted and compared. A byte that is both mismatched and mis-framed adds 2.
- `states_led`:
  - IDLE: 6'b000000.
  - SEND: 6'b010010.
  - RECV: 6'b100100.
  - `pass` = 1 while IDLE: 6'b001001 (overrides the IDLE value).
- `start` while busy is ignored.
- `start` in the DONE cycle is ignored. It is accepted on the next IDLE cycle if still high.

## Timing
- Reset values: `sig_tx` = 1, `busy` = 0, `done` = 0, `pass` = 0, `err_count` = 0, `timeout` = 0, `states_led` = 0. FSM goes to IDLE and all counters clear.
- Reset mid-run: the next cycle shows the reset values, and any partial frame is abandoned.
- `start` high in cycle N (IDLE): `busy` = 1 and `sig_tx` = 0 in cycle N+1.
- Every bit is exactly CPB cycles.
- SEND lasts FRAME_LEN × 10 × CPB cycles.
- Byte completion: compare and `err_count` update happen 1 cycle after the stop-bit sample.
- `done` occurs 1 cycle after the last byte completes. `busy` falls in the same cycle `done` rises.
- Counter widths:
  - Bit counter: 4 bits.
  - Cycle counter: ⌈log2(CPB)⌉ bits.
  - Byte indices: 9 bits, so FRAME_LEN = 256 is reachable.

## Configuration
- `UART_INIT_TIMEOUT_EN` defined: a watchdog runs in RECV only.
  - It clears on entry to RECV and on each completed rx byte.
  - On reaching TIMEOUT_BITS × CPB cycles, go to DONE with `timeout` = 1 and `pass` = 0. `err_count` is not changed.
  - A partially received byte is discarded.
- `UART_INIT_TIMEOUT_EN` undefined: no watchdog, so RECV waits indefinitely. `timeout` is constant 0 and TIMEOUT_BITS is unused.

## Test plan
All scenarios use CLK_FREQ = 16, BAUD = 1 (CPB = 16), FRAME_LEN = 4 and SEED = 8'hA0, with `sig_tx` looped to `sig_rx` unless noted.
- Clean loopback, `start` pulse → `sig_tx` carries A0, A1, A2, A3 in LSB-first 8N1 frames; 640 cycles of SEND; `done` pulse with `pass` = 1 and `err_count` = 0.
- Flip bit 0 of the third echoed byte (A2 received as A3) → `err_count` = 1, `pass` = 0, `states_led` = 0 after DONE.
- Force the stop bit of echoed byte 1 low → `err_count` = 1, `pass` = 0; 4 bytes still counted and `done` is reached.
- Drive a 3-cycle low glitch on an idle `sig_rx` during SEND → rejected as a false start; `err_count` = 0, `pass` = 1.
- Loop removed (`sig_rx` held high), macro defined, TIMEOUT_BITS = 20 → `done` 320 cycles after entry to RECV; `timeout` = 1, `pass` = 0.
- `reset` asserted mid-SEND, then `start` raised during the following run's `busy` → after reset, `sig_tx` = 1 and `busy` = 0 next cycle; the start during `busy` does not restart the run.
